// File: rtl/counter_arbiter_if.sv
// Handshake bundle between the two-requester arbiter, its requesters and the shared counter.
interface counter_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [WIDTH-1:0] cnt_count;

    modport master (
        output req, len0, len1, cnt_tc, cnt_count,
        input  gnt, done, busy, cnt_en, cnt_clr
    );

    modport slave (
        input  req, len0, len1, cnt_tc, cnt_count,
        output gnt, done, busy, cnt_en, cnt_clr
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting one of two requesters a run of N shared-counter periods,
// with a clear cycle before each run and a one-cycle completion pulse after it.
module counter_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 9,
    parameter int LEN_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    counter_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t           state_q;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic             cnt_en_q;
    logic             cnt_clr_q;
    logic [LEN_W-1:0] remaining_q;
    logic             last_q;
    logic             win_q;

    logic             win_d;
    logic [LEN_W-1:0] len_d;

    // With both requests high the requester not served last wins.
    always_comb begin
        win_d = bus.req[1];
        if (bus.req == 2'b11) begin
            win_d = ~last_q;
        end
        len_d = win_d ? bus.len1 : bus.len0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            remaining_q <= '0;
            last_q      <= 1'b1;
            win_q       <= 1'b0;
        end else begin
            done_q    <= 2'b00;
            cnt_clr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        win_q       <= win_d;
                        gnt_q       <= win_d ? 2'b10 : 2'b01;
                        remaining_q <= (len_d == '0) ? LEN_W'(1) : len_d;
                        cnt_clr_q   <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!bus.req[win_q]) begin
                        gnt_q    <= 2'b00;
                        cnt_en_q <= 1'b0;
                        last_q   <= win_q;
                        state_q  <= IDLE;
                    end else begin
                        cnt_en_q <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    // A dropped request wins over a coincident final terminal count.
                    if (!bus.req[win_q]) begin
                        gnt_q    <= 2'b00;
                        cnt_en_q <= 1'b0;
                        last_q   <= win_q;
                        state_q  <= IDLE;
                    end else if (bus.cnt_tc && cnt_en_q) begin
                        if (remaining_q == LEN_W'(1)) begin
                            gnt_q         <= 2'b00;
                            cnt_en_q      <= 1'b0;
                            done_q[win_q] <= 1'b1;
                            state_q       <= DONE;
                        end
                        remaining_q <= remaining_q - LEN_W'(1);
                    end
                end
                DONE: begin
                    last_q  <= win_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.cnt_en  = cnt_en_q;
    assign bus.cnt_clr = cnt_clr_q;
endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the shared counter's count value.
REQ-002 SHALL have parameter MAX_VALUE, default 9, the shared counter's terminal value; one period is MAX_VALUE+1 enabled cycles.
REQ-003 SHALL have parameter LEN_W, default 4, the width of the per-requester run length.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port req, input, 2, per-requester level request; bit i = requester i.
REQ-007 SHALL have port len0, input, LEN_W, requester 0 run length in counter periods.
REQ-008 SHALL have port len1, input, LEN_W, requester 1 run length in counter periods.
REQ-009 SHALL have port gnt, output, 2, one-hot grant, registered.
REQ-010 SHALL have port done, output, 2, one-cycle completion pulse per requester, registered.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port cnt_en, output, 1, enable to the shared counter.
REQ-013 SHALL have port cnt_clr, output, 1, synchronous clear to the shared counter.
REQ-014 SHALL have port cnt_tc, input, 1, terminal-count flag from the shared counter (high when count == MAX_VALUE).
REQ-015 SHALL have port cnt_count, input, WIDTH, count value from the shared counter, used only for the clear check in REQ-020.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, RUN and DONE.
REQ-017 IDLE: when req != 0, SHALL pick the winner on the next edge, go to CLEAR, set gnt, and latch remaining = len of the winner (len 0 treated as 1).
REQ-018 Arbitration SHALL be round-robin: if both requests are high, the requester not served last wins; the last-served pointer resets to 1, so requester 0 wins first.
REQ-019 CLEAR SHALL last exactly one cycle, with cnt_clr=1 and cnt_en=0, then go to RUN.
REQ-020 In RUN, cnt_en SHALL be 1; if cnt_count != 0 on the first RUN cycle, SHALL flag no error but SHALL still proceed (the check is informational only).
REQ-021 In RUN, each edge with cnt_tc=1 and cnt_en=1 SHALL decrement remaining; when remaining==1 on such an edge, SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with done[winner]=1, gnt=0 and cnt_en=0; SHALL update the last-served pointer and return to IDLE.
REQ-023 Latency: done SHALL rise exactly 10*len+1 cycles after gnt rises (MAX_VALUE=9); a new grant SHALL rise no earlier than 2 cycles after done.
REQ-024 If req[winner] drops in CLEAR or RUN, SHALL abort next edge to IDLE: gnt=0, cnt_en=0, no done pulse, pointer updated as if served.
REQ-025 len changes after grant SHALL be ignored; a request arriving while busy SHALL wait without loss.
REQ-026 gnt SHALL be one-hot or zero at all times; done and gnt SHALL never both be high for the same requester.

Reset
REQ-027 On rst low, SHALL immediately force state=IDLE, gnt=0, done=0, busy=0, cnt_en=0, cnt_clr=0, remaining=0 and pointer=1, independent of clk.
REQ-028 Reset mid-run SHALL discard the job with no done pulse; after rst rises, arbitration SHALL restart with requester 0 priority.

Verification
REQ-029 rst low 2 cycles, req=01, len0=1 -> gnt=01 one cycle later, cnt_clr pulse 1 cycle, done=01 exactly 11 cycles after gnt rise.
REQ-030 req=11 held, len0=2, len1=1 -> requester 0 first (done0 21 cycles after grant), then gnt=10, done1 11 cycles later, then gnt=01 again.
REQ-031 len1=0, req=10 -> treated as 1: done1 11 cycles after gnt.
REQ-032 req=01, len0=3, drop req at cycle 15 of RUN -> gnt=00 and cnt_en=0 next cycle, no done pulse, busy=0.
REQ-033 rst asserted asynchronously mid-RUN (between edges) -> gnt, cnt_en and busy go 0 without a clock edge; with req=11 after release, gnt=01.
REQ-034 Throughout all scenarios, checker asserts gnt is one-hot-or-zero and cnt_en=0 whenever gnt=0.
